dual_layer_fetch_scheduler: RTL and testbench

- Schedules per-line pixel prefetch for two display layers (LED layer 0 and LED layer 1) that share one memory read port.
- Placed between the 640x480@60Hz video timing generator and the shared pixel memory.
- Uses the generator's de and vsync to decide when the next line's data must be fetched.
- Arbitrates the two layers round-robin and runs a word-by-word req/ack burst for each granted layer.
- Flags a per-layer underrun when a fetch has not finished before the next line trigger.

---
 rtl/dual_layer_fetch_scheduler_if.sv | 24 ++
 rtl/dual_layer_fetch_scheduler.sv | 155 +++++++++++++++
 tb/tb_dual_layer_fetch_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_layer_fetch_scheduler_if.sv
// Shared pixel-memory read port: one word per req/ack handshake, tagged with
// the owning display layer.
interface dual_layer_fetch_scheduler_if #(
  parameter int ADDR_W = 16
) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_layer;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_layer,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_layer,
    output mem_ack
  );
endinterface

// File: rtl/dual_layer_fetch_scheduler.sv
// Per-line prefetch scheduler for two display layers sharing one memory read
// port: round-robin arbitration, word bursts, sticky underrun on late fetches.
module dual_layer_fetch_scheduler #(
  parameter int ADDR_W     = 16,
  parameter int LINE_WORDS = 20,
  parameter int V_ACTIVE   = 480
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          de,
  input  logic                          vsync,
  input  logic [1:0]                    layer_en,
  input  logic [ADDR_W-1:0]             base0,
  input  logic [ADDR_W-1:0]             base1,
  dual_layer_fetch_scheduler_if.master  mem,
  output logic [8:0]                    line_idx,
  output logic                          busy,
  output logic [1:0]                    underrun,
  input  logic                          underrun_clr
);

  localparam int CNT_W = $clog2(LINE_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    FETCH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              de_q, vsync_q;
  logic [8:0]        line_idx_q, line_idx_d;
  logic [1:0]        pending_q, pending_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              layer_q, layer_d;
  logic [1:0]        underrun_q, underrun_d;

  logic              frame_trig, line_trig, trig_valid;
  logic [9:0]        next_line;
  logic [8:0]        target;
  logic              grant;
  logic [ADDR_W-1:0] base_g, line_base;

  // A line trigger that would step past the last active line is swallowed;
  // a frame trigger always restarts at line 0 and beats a coincident line trigger.
  assign frame_trig = vsync_q & ~vsync;
  assign line_trig  = de_q & ~de;
  assign next_line  = {1'b0, line_idx_q} + 10'd1;
  assign trig_valid = frame_trig | (line_trig & (next_line != 10'(V_ACTIVE)));
  assign target     = frame_trig ? 9'd0 : next_line[8:0];

  assign grant     = pending_q[~rr_q] ? ~rr_q : rr_q;
  assign base_g    = grant ? base1 : base0;
  assign line_base = ADDR_W'(line_idx_q) * ADDR_W'(LINE_WORDS);

  always_comb begin
    // NOTE: every next-state variable takes its hold value first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    state_d    = state_q;
    line_idx_d = line_idx_q;
    pending_d  = pending_q;
    rr_d       = rr_q;
    word_cnt_d = word_cnt_q;
    req_d      = req_q;
    addr_d     = addr_q;
    layer_d    = layer_q;
    underrun_d = underrun_q;

    case (state_q)
      IDLE: begin
        if (pending_q != 2'b00) state_d = ARB;
      end
      ARB: begin
        if (pending_q != 2'b00) begin
          layer_d    = grant;
          addr_d     = base_g + line_base;
          word_cnt_d = '0;
          req_d      = 1'b1;
          state_d    = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (req_q && mem.mem_ack) begin
          word_cnt_d = word_cnt_q + 1'b1;
          addr_d     = addr_q + 1'b1;
          if (word_cnt_q == LAST_WORD) begin
            req_d              = 1'b0;
            pending_d[layer_q] = 1'b0;
            rr_d               = layer_q;
            state_d            = ARB;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (underrun_clr) underrun_d = 2'b00;

    // A new line pre-empts everything: unfinished layers are flagged, any
    // in-flight burst is dropped and a word acked this cycle is discarded.
    if (trig_valid) begin
      line_idx_d = target;
      pending_d  = layer_en;
      underrun_d = underrun_d | pending_q;
      req_d      = 1'b0;
      addr_d     = addr_q;
      word_cnt_d = word_cnt_q;
      state_d    = (state_q == IDLE) ? IDLE : ARB;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      de_q       <= 1'b0;
      vsync_q    <= 1'b0;
      line_idx_q <= '0;
      pending_q  <= '0;
      rr_q       <= 1'b0;
      word_cnt_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      layer_q    <= 1'b0;
      underrun_q <= '0;
    end else begin
      state_q    <= state_d;
      de_q       <= de;
      vsync_q    <= vsync;
      line_idx_q <= line_idx_d;
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      word_cnt_q <= word_cnt_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      layer_q    <= layer_d;
      underrun_q <= underrun_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_layer = layer_q;
  assign line_idx      = line_idx_q;
  assign underrun      = underrun_q;
  assign busy          = (state_q != IDLE) | (pending_q != 2'b00);

endmodule

// File: tb/tb_dual_layer_fetch_scheduler.sv
// Self-checking bench: directed frame/line/underrun/reset scenarios plus
// randomized lines, checked against a word-list model of each line's fetch.
module tb_dual_layer_fetch_scheduler;

  localparam int ADDR_W = 16;
  localparam int LW     = 20;
  localparam int VA     = 480;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        de = 1'b0;
  logic        vsync = 1'b1;
  logic        underrun_clr = 1'b0;
  logic [1:0]  layer_en = 2'b00;
  logic [15:0] base0 = '0;
  logic [15:0] base1 = '0;
  logic [8:0]  line_idx;
  logic        busy;
  logic [1:0]  underrun;

  dual_layer_fetch_scheduler_if #(.ADDR_W(ADDR_W)) mem ();

  dual_layer_fetch_scheduler #(
    .ADDR_W(ADDR_W), .LINE_WORDS(LW), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .resetn(resetn), .de(de), .vsync(vsync),
    .layer_en(layer_en), .base0(base0), .base1(base1), .mem(mem),
    .line_idx(line_idx), .busy(busy), .underrun(underrun),
    .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          ack_mode = 0;  // 0 low, 1 high, 2 every 4th cycle, 3 random
  int unsigned cyc = 0;
  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];
  int unsigned m_line = 0;
  logic        m_rr = 1'b0;   // layer that most recently completed a line

  always @(posedge clk) begin
    cyc++;
    #2;
    case (ack_mode)
      0:       mem.mem_ack = 1'b0;
      1:       mem.mem_ack = 1'b1;
      2:       mem.mem_ack = (cyc % 4 == 0);
      default: mem.mem_ack = 1'($urandom_range(0, 1));
    endcase
  end

  always @(posedge clk)
    if (resetn && mem.mem_req && mem.mem_ack)
      obs_q.push_back({mem.mem_layer, mem.mem_addr});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line_pulse(input logic clr);
    de = 1'b1;
    step();
    de = 1'b0;
    underrun_clr = clr;
    step();
    underrun_clr = 1'b0;
  endtask

  task automatic frame_pulse();
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
  endtask

  task automatic push_layer(input logic l, input logic [15:0] b);
    logic [15:0] a;
    for (int w = 0; w < LW; w++) begin
      a = b + 16'(m_line * LW) + 16'(w);
      exp_q.push_back({l, a});
    end
  endtask

  // One line's expected word stream: when both layers want the line, the one
  // that did not finish last goes first; the last one to finish becomes m_rr.
  task automatic model_line(input logic [1:0] en, input logic [15:0] b0, input logic [15:0] b1);
    logic la, lb;
    if (en == 2'b11) begin
      la = ~m_rr;
      lb = m_rr;
      push_layer(la, la ? b1 : b0);
      push_layer(lb, lb ? b1 : b0);
      m_rr = lb;
    end else if (en != 2'b00) begin
      la = en[1];
      push_layer(la, la ? b1 : b0);
      m_rr = la;
    end
  endtask

  task automatic compare_log(input string tag);
    int n;
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_w%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      step();
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},      32'(mem.mem_req),   32'd0);
    check({tag, "_addr"},     32'(mem.mem_addr),  32'd0);
    check({tag, "_layer"},    32'(mem.mem_layer), 32'd0);
    check({tag, "_line"},     32'(line_idx),      32'd0);
    check({tag, "_busy"},     32'(busy),          32'd0);
    check({tag, "_underrun"}, 32'(underrun),      32'd0);
  endtask

  initial begin
    logic [1:0]  en;
    logic [15:0] b0, b1;
    logic        rr0;
    int          k;

    // Reset values
    step(3);
    check_reset_state("reset");
    resetn = 1'b1;
    step(2);

    // Frame start, both layers, ack tied high
    layer_en = 2'b11; base0 = 16'h0000; base1 = 16'h4000; ack_mode = 1;
    obs_q.delete();
    frame_pulse();
    m_line = 0;
    check("frame0_line", 32'(line_idx), m_line);
    model_line(2'b11, base0, base1);
    wait_idle("frame0", 200);
    compare_log("frame0");

    // Advance to line 5 with no layers, then fetch line 6 for layer 0
    layer_en = 2'b00;
    repeat (5) begin
      line_pulse(1'b0);
      m_line++;
    end
    check("line5", 32'(line_idx), 32'd5);
    layer_en = 2'b01; base0 = 16'h1000;
    line_pulse(1'b0);
    m_line++;
    check("line6", 32'(line_idx), 32'd6);
    model_line(2'b01, base0, base1);
    wait_idle("line6", 200);
    compare_log("line6");

    // Randomized lines: random enables, bases, skips and ack pattern
    for (int it = 0; it < 6; it++) begin
      layer_en = 2'b00;
      k = int'($urandom_range(0, 3));
      repeat (k) begin
        line_pulse(1'b0);
        m_line++;
      end
      en = (it == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      b0 = (it == 0) ? 16'hFFF8 : 16'($urandom);
      b1 = 16'($urandom);
      layer_en = en; base0 = b0; base1 = b1; ack_mode = 3;
      line_pulse(1'b0);
      m_line++;
      check($sformatf("rand%0d_line", it), 32'(line_idx), m_line);
      model_line(en, b0, b1);
      wait_idle($sformatf("rand%0d", it), 600);
      compare_log($sformatf("rand%0d", it));
      check($sformatf("rand%0d_underrun", it), 32'(underrun), 32'd0);
      ack_mode = 1;
    end

    // Underrun: slow acks, new line arrives after 30 words
    layer_en = 2'b11; base0 = 16'h2000; base1 = 16'h3000; ack_mode = 2;
    line_pulse(1'b0);
    m_line++;
    rr0 = m_rr;
    model_line(2'b11, base0, base1);
    m_rr = ~rr0;
    while (exp_q.size() > 30) void'(exp_q.pop_back());
    for (int i = 0; i < 2000; i++) begin
      if (obs_q.size() >= 30) break;
      step();
    end
    ack_mode = 0;
    compare_log("ur_pre");
    step(2);
    line_pulse(1'b0);
    m_line++;
    check("ur_req_drop", 32'(mem.mem_req), 32'd0);
    check("ur_flag", 32'(underrun), 32'(rr0 ? 2'b10 : 2'b01));
    check("ur_line", 32'(line_idx), m_line);
    ack_mode = 1;
    model_line(2'b11, base0, base1);
    wait_idle("ur_next", 300);
    compare_log("ur_next");

    // underrun_clr alone, then coinciding with a new underrun
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("clr_alone", 32'(underrun), 32'd0);
    layer_en = 2'b01; ack_mode = 0;
    line_pulse(1'b0);
    m_line++;
    step(3);
    check("stall_req", 32'(mem.mem_req), 32'd1);
    line_pulse(1'b1);
    m_line++;
    check("clr_vs_set", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("clr_after", 32'(underrun), 32'd0);

    // Last active line: trigger past 479 is ignored
    layer_en = 2'b00;
    while (m_line < VA - 1) begin
      line_pulse(1'b0);
      m_line++;
    end
    check("line479", 32'(line_idx), 32'd479);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    obs_q.delete();
    layer_en = 2'b11; ack_mode = 1;
    line_pulse(1'b0);
    step(3);
    check("l479_hold", 32'(line_idx), 32'd479);
    check("l479_req", 32'(mem.mem_req), 32'd0);
    check("l479_busy", 32'(busy), 32'd0);
    check("l479_words", 32'(obs_q.size()), 32'd0);
    frame_pulse();
    m_line = 0;
    check("frame1_line", 32'(line_idx), 32'd0);
    model_line(2'b11, base0, base1);
    wait_idle("frame1", 200);
    compare_log("frame1");

    // Asynchronous reset in the middle of a burst
    ack_mode = 0;
    line_pulse(1'b0);
    step(4);
    check("pre_rst_req", 32'(mem.mem_req), 32'd1);
    check("pre_rst_line", 32'(line_idx), 32'd1);
    #3 resetn = 1'b0;
    #1;
    check_reset_state("async_rst");
    step(2);
    resetn = 1'b1;
    m_rr = 1'b0;
    m_line = 0;
    obs_q.delete();
    exp_q.delete();
    step(2);
    ack_mode = 1; base0 = 16'h0100; base1 = 16'h0200;
    frame_pulse();
    check("post_rst_line", 32'(line_idx), 32'd0);
    model_line(2'b11, base0, base1);
    wait_idle("post_rst", 200);
    compare_log("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
